seq_divider_32x16: RTL and testbench

Sequential radix-2 restoring divider. It divides a 2*BIT-bit dividend by a BIT-bit divisor and returns a BIT-bit quotient and a BIT-bit remainder. It is the inverse of the team's 16x16 Dadda multiplier: for any a, b and r < b, feeding it a*b + r with divisor b returns quotient a and remainder r. Valid/ready handshakes on input and output let it sit in the same datapath as the multiplier.

---
 rtl/seq_divider_32x16.sv | 143 ++++++++++++++
 tb/tb_seq_divider_32x16.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32x16.sv
// Sequential radix-2 restoring divider: 2*BIT-bit dividend / BIT-bit divisor,
// one quotient bit per cycle, with valid/ready handshakes on both sides.
module seq_divider_32x16 #(
    parameter int unsigned BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*BIT-1:0] dividend,
    input  logic [BIT-1:0]   divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIT-1:0]   quotient,
    output logic [BIT-1:0]   remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(BIT);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_next;
    logic [BIT:0]   r_reg;
    logic [BIT-1:0] q_reg;
    logic [BIT-1:0] dvs_reg;
    logic [CW-1:0]  counter;

    logic           accept;
    logic           zero_div;
    logic           ovf_div;
    logic           last_step;
    logic [BIT+1:0] shifted;
    logic [BIT+1:0] diff;
    logic [BIT:0]   r_step;
    logic [BIT-1:0] q_step;

    always_comb begin
        accept    = in_valid && in_ready;
        zero_div  = (divisor == '0);
        ovf_div   = (dividend[2*BIT-1:BIT] >= divisor);
        last_step = (counter == CW'(BIT - 1));
    end

    // One restoring step; the extra top bit of diff acts as the borrow flag.
    always_comb begin
        shifted = {r_reg, q_reg[BIT-1]};
        diff    = shifted - {2'b00, dvs_reg};
        if (diff[BIT+1]) begin
            r_step = shifted[BIT:0];
            q_step = {q_reg[BIT-2:0], 1'b0};
        end else begin
            r_step = diff[BIT:0];
            q_step = {q_reg[BIT-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (zero_div || ovf_div) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg       <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            counter     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvs_reg <= divisor;
                        counter <= '0;
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend[BIT-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (ovf_div) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            r_reg       <= {1'b0, dividend[2*BIT-1:BIT]};
                            q_reg       <= dividend[BIT-1:0];
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_reg   <= r_step;
                    q_reg   <= q_step;
                    counter <= counter + CW'(1);
                    if (last_step) begin
                        quotient  <= q_step;
                        remainder <= r_step[BIT-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32x16.sv
// Randomised self-checking bench for seq_divider_32x16 against an arithmetic
// reference model (plain / and %), plus directed corner cases.
module tb_seq_divider_32x16;

    localparam int unsigned BIT = 16;
    localparam int unsigned N_RAND = 2000;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     dividend;
    logic [15:0]     divisor;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     quotient;
    logic [15:0]     remainder;
    logic            div_by_zero;
    logic            overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_divider_32x16 #(.BIT(BIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {div_by_zero, overflow, quotient, remainder}.
    function automatic logic [33:0] ref_div(input logic [31:0] dd, input logic [15:0] dv);
        logic [31:0] q;
        if (dv == 16'd0) return {1'b1, 1'b0, 16'hFFFF, dd[15:0]};
        q = dd / {16'd0, dv};
        if (q > 32'h0000_FFFF) return {1'b0, 1'b1, 16'hFFFF, 16'h0000};
        return {1'b0, 1'b0, q[15:0], 16'(dd % {16'd0, dv})};
    endfunction

    // Called at a negedge with the block idle. hold = cycles of backpressure.
    task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                          input logic [33:0] exp, input int exp_lat, input int hold);
        int cycles;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        cycles   = 1;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, "_quotient"}, 32'(quotient), 32'(exp[31:16]));
        check({tag, "_remainder"}, 32'(remainder), 32'(exp[15:0]));
        check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(exp[33]));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            dividend = $urandom;
            divisor  = 16'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_quotient"}, 32'(quotient), 32'(exp[31:16]));
            check({tag, "_hold_remainder"}, 32'(remainder), 32'(exp[15:0]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_r[$];

    initial begin
        logic [31:0] a, b, r;
        logic [31:0] dd;
        logic [15:0] dv;
        int          n_acc, n_done, last_acc, saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("basic", 32'd100000, 16'd300, {2'b00, 16'd333, 16'd100}, 17, 0);
        run_op("max_inv0", 32'hFFFE0001, 16'hFFFF, {2'b00, 16'hFFFF, 16'h0000}, 17, 0);
        run_op("max_inv1", 32'hFFFEFFFF, 16'hFFFF, {2'b00, 16'hFFFF, 16'hFFFE}, 17, 0);
        run_op("div_zero", 32'h12345678, 16'd0, {2'b10, 16'hFFFF, 16'h5678}, 1, 0);
        run_op("ovf", 32'h00010000, 16'd1, {2'b01, 16'hFFFF, 16'h0000}, 1, 0);
        run_op("ovf_edge", 32'h0000FFFF, 16'd1, {2'b00, 16'hFFFF, 16'h0000}, 17, 0);
        run_op("backpress", 32'd987654, 16'd1234, ref_div(32'd987654, 16'd1234), 17, 5);

        for (int k = 0; k < 6; k++) begin
            dd = $urandom;
            dv = (k == 0) ? 16'd0 : ((k < 3) ? 16'($urandom_range(1, 255)) : 16'($urandom));
            run_op("rand_dir", dd, dv, ref_div(dd, dv), (dv == 16'd0 || dd[31:16] >= dv) ? 1 : 17, k % 3);
        end

        // Abort an operation partway through CALC.
        dividend = 32'h0BAD_F00D;
        divisor  = 16'd99;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        saw_valid = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        check("abort_no_result", 32'(saw_valid), 32'd0);
        run_op("after_abort", 32'd1000, 16'd7, {2'b00, 16'd142, 16'd6}, 17, 0);

        // Back-to-back random a*b+r with out_ready tied high.
        out_ready = 1'b1;
        n_acc     = 0;
        n_done    = 0;
        last_acc  = 0;
        for (int cyc = 0; cyc < 60000 && n_done < int'(N_RAND); cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    check("b2b_quotient", 32'(quotient), exp_q.pop_front());
                    check("b2b_remainder", 32'(remainder), exp_r.pop_front());
                    check("b2b_flags", {30'd0, div_by_zero, overflow}, 32'd0);
                end
                n_done++;
            end
            if (in_ready) begin
                if (n_acc < int'(N_RAND)) begin
                    b = $urandom_range(1, 65535);
                    if (n_acc % 4 == 0) b = $urandom_range(1, 15);
                    a = $urandom_range(0, 65535);
                    r = $urandom % b;
                    dividend = a * b + r;
                    divisor  = b[15:0];
                    in_valid = 1'b1;
                    exp_q.push_back(a);
                    exp_r.push_back(r);
                    if (n_acc > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd18);
                    last_acc = cyc;
                    n_acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_completed", 32'(n_done), 32'(N_RAND));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
